store_commit_buffer: RTL and testbench

STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

---
 rtl/store_commit_buffer.sv | 157 +++++++++++++++
 tb/tb_store_commit_buffer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_commit_buffer.sv
// rtl/store_commit_buffer.sv - two-wide committed-store FIFO with in-order drain and byte-merged load forwarding
module store_commit_buffer #(
    parameter int SCB_ENTRIES   = 8,
    parameter int CPU_ADDR_BITS = 32,
    parameter int CPU_DATA_BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_val0,
    input  logic                     st_val1,
    input  logic [CPU_ADDR_BITS-1:0] st_addr0,
    input  logic [CPU_ADDR_BITS-1:0] st_addr1,
    input  logic [CPU_DATA_BITS-1:0] st_data0,
    input  logic [CPU_DATA_BITS-1:0] st_data1,
    input  logic [3:0]               st_be0,
    input  logic [3:0]               st_be1,
    output logic [1:0]               scb_rdy,
    output logic                     mem_req,
    input  logic                     mem_gnt,
    output logic [CPU_ADDR_BITS-1:0] mem_addr,
    output logic [CPU_DATA_BITS-1:0] mem_wdata,
    output logic [3:0]               mem_be,
    input  logic [CPU_ADDR_BITS-1:0] ld_addr,
    input  logic [3:0]               ld_be,
    output logic                     fwd_hit,
    output logic [CPU_DATA_BITS-1:0] fwd_data,
    output logic                     fwd_stall,
    output logic                     scb_empty
);

    localparam int IDX_W = $clog2(SCB_ENTRIES);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH = PTR_W'(SCB_ENTRIES);

    logic [PTR_W-1:0]         head;
    logic [PTR_W-1:0]         tail;
    logic [PTR_W-1:0]         count;
    logic [PTR_W-1:0]         free_cnt;
    logic [SCB_ENTRIES-1:0]   ent_valid;
    logic [CPU_ADDR_BITS-1:0] ent_addr [SCB_ENTRIES];
    logic [CPU_DATA_BITS-1:0] ent_data [SCB_ENTRIES];
    logic [3:0]               ent_be   [SCB_ENTRIES];

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic [IDX_W-1:0] wr1_idx;
    logic             empty;
    logic             full;
    logic             drain;
    logic             enq0;
    logic             enq1;
    logic [1:0]       enq_cnt;
    logic [1:0]       enq_req_cnt;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    assign count    = tail - head;
    assign free_cnt = DEPTH - count;

    // Ready comes from registered occupancy only; a same-cycle drain gives no credit.
    assign scb_rdy[0] = !full;
    assign scb_rdy[1] = (free_cnt >= PTR_W'(2));

    // Compacted enqueue: whichever slots are valid fill tail, tail+1 in slot order.
    assign enq0        = st_val0 && scb_rdy[0];
    assign enq1        = st_val1 && (st_val0 ? scb_rdy[1] : scb_rdy[0]);
    assign enq_cnt     = {1'b0, enq0} + {1'b0, enq1};
    assign enq_req_cnt = {1'b0, st_val0} + {1'b0, st_val1};
    assign wr1_idx     = tail_idx + IDX_W'(enq0);
    assign drain       = !empty && mem_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
        end else begin
            head <= head + PTR_W'(drain);
            tail <= tail + PTR_W'(enq_cnt);
            // A write never lands on the draining slot: that needs a full buffer, where enqueue is refused.
            if (drain) begin
                ent_valid[head_idx] <= 1'b0;
            end
            if (enq0) begin
                ent_valid[tail_idx] <= 1'b1;
            end
            if (enq1) begin
                ent_valid[wr1_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq0) begin
            ent_addr[tail_idx] <= st_addr0;
            ent_data[tail_idx] <= st_data0;
            ent_be[tail_idx]   <= st_be0;
        end
        if (enq1) begin
            ent_addr[wr1_idx] <= st_addr1;
            ent_data[wr1_idx] <= st_data1;
            ent_be[wr1_idx]   <= st_be1;
        end
    end

    assign mem_req   = !empty;
    assign scb_empty = empty;
    assign mem_addr  = empty ? '0 : ent_addr[head_idx];
    assign mem_wdata = empty ? '0 : ent_data[head_idx];
    assign mem_be    = empty ? '0 : ent_be[head_idx];

    logic [3:0]               fwd_cov;
    logic [3:0]               fwd_req_cov;
    logic [CPU_DATA_BITS-1:0] fwd_merge;
    logic [IDX_W-1:0]         scan_idx;

    // Walk oldest to youngest from head so later matches overwrite earlier ones, across the wrap.
    always_comb begin
        fwd_cov   = '0;
        fwd_merge = '0;
        scan_idx  = head_idx;
        for (int k = 0; k < SCB_ENTRIES; k++) begin
            scan_idx = head_idx + IDX_W'(k);
            if (ent_valid[scan_idx] &&
                (ent_addr[scan_idx][CPU_ADDR_BITS-1:2] == ld_addr[CPU_ADDR_BITS-1:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (ent_be[scan_idx][b]) begin
                        fwd_cov[b]          = 1'b1;
                        fwd_merge[8*b +: 8] = ent_data[scan_idx][8*b +: 8];
                    end
                end
            end
        end
    end

    assign fwd_req_cov = fwd_cov & ld_be;
    assign fwd_hit     = (ld_be != 4'b0) && (fwd_req_cov == ld_be);
    assign fwd_stall   = (fwd_req_cov != 4'b0) && (fwd_req_cov != ld_be);

    always_comb begin
        fwd_data = '0;
        for (int b = 0; b < 4; b++) begin
            if (fwd_req_cov[b]) begin
                fwd_data[8*b +: 8] = fwd_merge[8*b +: 8];
            end
        end
    end

    logic unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[1:0];

    enq_within_free: assert property (@(posedge clk) disable iff (!rst)
        PTR_W'(enq_req_cnt) <= free_cnt);

endmodule

// File: tb/tb_store_commit_buffer.sv
// tb/tb_store_commit_buffer.sv - directed self-checking bench for store_commit_buffer
module tb_store_commit_buffer;

    logic        clk;
    logic        rst;
    logic        st_val0, st_val1;
    logic [31:0] st_addr0, st_addr1;
    logic [31:0] st_data0, st_data1;
    logic [3:0]  st_be0, st_be1;
    logic [1:0]  scb_rdy;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        fwd_stall;
    logic        scb_empty;

    int n_tests = 0;
    int n_fail  = 0;

    store_commit_buffer #(
        .SCB_ENTRIES(8),
        .CPU_ADDR_BITS(32),
        .CPU_DATA_BITS(32)
    ) dut (
        .clk(clk), .rst(rst),
        .st_val0(st_val0), .st_val1(st_val1),
        .st_addr0(st_addr0), .st_addr1(st_addr1),
        .st_data0(st_data0), .st_data1(st_data1),
        .st_be0(st_be0), .st_be1(st_be1),
        .scb_rdy(scb_rdy),
        .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .ld_addr(ld_addr), .ld_be(ld_be),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
        .scb_empty(scb_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic v0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                       input logic v1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] b1);
        st_val0 = v0; st_addr0 = a0; st_data0 = d0; st_be0 = b0;
        st_val1 = v1; st_addr1 = a1; st_data1 = d1; st_be1 = b1;
    endtask

    task automatic idle();
        put(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int exp_q[$];
    int mcount, sent, cyc, n, k;
    logic g, dr, odd;

    initial begin
        rst = 1'b0; mem_gnt = 1'b0; ld_addr = 32'h0; ld_be = 4'hF;
        idle();
        repeat (2) @(negedge clk);

        check("rst_mem_req", mem_req, 1'b0);
        check("rst_rdy", scb_rdy, 2'b11);
        check("rst_empty", scb_empty, 1'b1);
        check("rst_fwd_hit", fwd_hit, 1'b0);
        check("rst_fwd_stall", fwd_stall, 1'b0);
        check("rst_fwd_data", fwd_data, 32'h0);
        check("rst_payload", {mem_addr, mem_wdata}, 64'h0);
        check("rst_mem_be", mem_be, 4'h0);
        rst = 1'b1; ld_be = 4'h0;
        @(negedge clk);

        // Dual enqueue with grant held high: one drain per cycle in commit order
        mem_gnt = 1'b1;
        put(1'b1, 32'h100, 32'hAAAA_AAAA, 4'hF, 1'b1, 32'h104, 32'hBBBB_BBBB, 4'hF);
        step(); idle();
        check("dual_req", mem_req, 1'b1);
        check("dual_addr0", mem_addr, 32'h100);
        check("dual_data0", mem_wdata, 32'hAAAA_AAAA);
        check("dual_be0", mem_be, 4'hF);
        step();
        check("dual_addr1", mem_addr, 32'h104);
        check("dual_data1", mem_wdata, 32'hBBBB_BBBB);
        step();
        check("dual_empty", scb_empty, 1'b1);
        check("dual_req_off", mem_req, 1'b0);

        // Fill to full without grant, hold, then a single grant
        mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1'b1, 32'h400 + 32'(8*i), 32'(2*i), 4'hF, 1'b1, 32'h404 + 32'(8*i), 32'(2*i+1), 4'hF);
            step();
            if (i == 2) check("fill6_rdy", scb_rdy, 2'b11);
        end
        idle();
        check("full_rdy", scb_rdy, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_addr", mem_addr, 32'h400);
            check("hold_data", mem_wdata, 32'h0);
        end
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        check("gnt1_rdy", scb_rdy, 2'b01);
        check("gnt1_addr", mem_addr, 32'h404);
        check("gnt1_data", mem_wdata, 32'h1);
        mem_gnt = 1'b1; repeat (7) step(); mem_gnt = 1'b0;
        check("fill_drained", scb_empty, 1'b1);

        // Byte merge from youngest matching entry
        put(1'b1, 32'h200, 32'h0000_1111, 4'h3, 1'b0, 32'h0, 32'h0, 4'h0); step();
        put(1'b1, 32'h200, 32'h0000_0022, 4'h1, 1'b0, 32'h0, 32'h0, 4'h0); step();
        idle();
        ld_addr = 32'h200; ld_be = 4'h3; #1;
        check("merge_hit", fwd_hit, 1'b1);
        check("merge_stall", fwd_stall, 1'b0);
        check("merge_data", fwd_data, 32'h0000_1122);
        ld_be = 4'hF; #1;
        check("merge_partial", {fwd_hit, fwd_stall}, 2'b01);
        check("merge_partial_data", fwd_data, 32'h0000_1122);
        ld_be = 4'h0; #1;
        check("merge_be0", {fwd_hit, fwd_stall}, 2'b00);
        ld_addr = 32'h202; ld_be = 4'h2; #1;
        check("merge_offs", {fwd_hit, fwd_stall, fwd_data}, {2'b10, 32'h0000_1100});
        put(1'b1, 32'h208, 32'h0000_00AA, 4'h1, 1'b1, 32'h208, 32'h0000_00BB, 4'h1); step(); idle();
        ld_addr = 32'h208; ld_be = 4'h1; #1;
        check("slot1_younger", {fwd_hit, fwd_data}, {1'b1, 32'h0000_00BB});
        mem_gnt = 1'b1; repeat (4) step(); mem_gnt = 1'b0;
        check("merge_drained", scb_empty, 1'b1);

        // Age order across the index wrap (entries at 6, 7, 0)
        put(1'b1, 32'h600, 32'h1111_1111, 4'hF, 1'b1, 32'h600, 32'h2222_0000, 4'hC); step();
        put(1'b1, 32'h600, 32'h0000_3333, 4'h3, 1'b0, 32'h0, 32'h0, 4'h0); step(); idle();
        ld_addr = 32'h600; ld_be = 4'hF; #1;
        check("wrap_fwd", {fwd_hit, fwd_data}, {1'b1, 32'h2222_3333});
        mem_gnt = 1'b1; repeat (3) step(); mem_gnt = 1'b0;

        // Partial coverage and address mismatch
        put(1'b1, 32'h300, 32'h0000_0055, 4'h1, 1'b0, 32'h0, 32'h0, 4'h0); step(); idle();
        ld_addr = 32'h300; ld_be = 4'hF; #1;
        check("part_stall", {fwd_hit, fwd_stall}, 2'b01);
        ld_addr = 32'h304; #1;
        check("miss", {fwd_hit, fwd_stall}, 2'b00);
        ld_addr = 32'h300; ld_be = 4'h1; #1;
        check("part_full", {fwd_hit, fwd_data}, {1'b1, 32'h0000_0055});
        ld_be = 4'h0;
        mem_gnt = 1'b1; step(); mem_gnt = 1'b0;
        check("part_drained", scb_empty, 1'b1);

        // 20 stores with random grant gaps; scoreboard tracks order and occupancy
        mcount = 0; sent = 0; cyc = 0;
        while ((sent < 20 || exp_q.size() != 0) && cyc < 300) begin
            check("wrap_rdy", scb_rdy, {mcount <= 6, mcount <= 7});
            check("wrap_req", mem_req, mcount != 0);
            g = (cyc < 6) ? 1'b0 : ($urandom_range(0, 2) != 0);
            mem_gnt = g;
            dr = g && (exp_q.size() != 0);
            if (dr) begin
                k = exp_q.pop_front();
                check("wrap_addr", mem_addr, 32'h1000 + 32'(4*k));
                check("wrap_data", mem_wdata, 32'hC0DE_0000 | 32'(k));
            end
            n = (cyc % 4 == 3) ? 1 : 2;
            if (n == 2 && !(mcount <= 6)) n = 1;
            if (!(mcount <= 7)) n = 0;
            if (n > 20 - sent) n = 20 - sent;
            odd = cyc[0];
            idle();
            if (n == 2) begin
                put(1'b1, 32'h1000 + 32'(4*sent), 32'hC0DE_0000 | 32'(sent), 4'hF,
                    1'b1, 32'h1000 + 32'(4*(sent+1)), 32'hC0DE_0000 | 32'(sent+1), 4'hF);
            end else if (n == 1 && odd) begin
                put(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h1000 + 32'(4*sent), 32'hC0DE_0000 | 32'(sent), 4'hF);
            end else if (n == 1) begin
                put(1'b1, 32'h1000 + 32'(4*sent), 32'hC0DE_0000 | 32'(sent), 4'hF, 1'b0, 32'h0, 32'h0, 4'h0);
            end
            for (int j = 0; j < n; j++) exp_q.push_back(sent + j);
            sent = sent + n;
            step();
            mcount = mcount + n - int'(dr);
            cyc++;
        end
        idle(); mem_gnt = 1'b0;
        check("wrap_timeout", cyc < 300, 1'b1);
        check("wrap_empty", scb_empty, 1'b1);

        // Reset while draining is held off
        put(1'b1, 32'h700, 32'h7, 4'hF, 1'b1, 32'h704, 32'h8, 4'hF); step();
        put(1'b1, 32'h708, 32'h9, 4'hF, 1'b1, 32'h70C, 32'hA, 4'hF); step();
        put(1'b1, 32'h710, 32'hB, 4'hF, 1'b0, 32'h0, 32'h0, 4'h0); step(); idle();
        check("pre_rst_req", mem_req, 1'b1);
        check("pre_rst_rdy", scb_rdy, 2'b11);
        #2 rst = 1'b0;
        #1;
        check("midrst_req", mem_req, 1'b0);
        check("midrst_empty", scb_empty, 1'b1);
        check("midrst_payload", {mem_addr, mem_wdata}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        mem_gnt = 1'b1;
        put(1'b1, 32'h800, 32'h77, 4'hF, 1'b0, 32'h0, 32'h0, 4'h0); step(); idle();
        check("post_rst_addr", mem_addr, 32'h800);
        check("post_rst_data", mem_wdata, 32'h77);
        step();
        check("post_rst_empty", scb_empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
